// File: rtl/masked_xor_pipe.sv
// Share-wise XOR of two Boolean-masked operands with optional ring refresh,
// followed by a valid/ready register pipeline that isolates glitches between masked layers.
module masked_xor_pipe #(
    parameter int WIDTH   = 8,
    parameter int SHARES  = 3,
    parameter int STAGES  = 1,
    parameter int REFRESH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SHARES*WIDTH-1:0] a,
    input  logic [SHARES*WIDTH-1:0] b,
    input  logic [SHARES*WIDTH-1:0] rnd,
    input  logic                    rnd_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SHARES*WIDTH-1:0] z
);

    localparam int DW = SHARES * WIDTH;

    logic              advance;
    logic              transfer;
    logic [DW-1:0]     mask;
    logic [DW-1:0]     stage1_d;
    logic [STAGES-1:0] stage_vld;
    logic [DW-1:0]     stage_data [STAGES];

    assign advance  = !stage_vld[STAGES-1] || out_ready;
    assign transfer = in_valid && in_ready;

    // Without refresh the randomness port is irrelevant, so acceptance only waits on the pipe.
    if (REFRESH != 0) begin : g_ready_rnd
        assign in_ready = advance && rnd_valid;
    end else begin : g_ready_plain
        assign in_ready = advance;
    end

    // Each r_j enters exactly two shares, so every mask word cancels in the unshared value.
    if (REFRESH == 0) begin : g_mask_none
        logic unused_rnd;
        assign mask       = '0;
        assign unused_rnd = ^{rnd, rnd_valid};
    end else if (SHARES == 2) begin : g_mask_pair
        logic unused_rnd;
        assign mask       = {2{rnd[WIDTH-1:0]}};
        assign unused_rnd = ^rnd[2*WIDTH-1:WIDTH];
    end else begin : g_mask_ring
        for (genvar i = 0; i < SHARES; i++) begin : g_share
            assign mask[i*WIDTH +: WIDTH] = rnd[i*WIDTH +: WIDTH]
                                          ^ rnd[((i + SHARES - 1) % SHARES)*WIDTH +: WIDTH];
        end
    end

    assign stage1_d = a ^ b ^ mask;

    // All stages move in lockstep; a bubble still loads stage-1 data, which is simply ignored downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_data[s] <= '0;
            end
        end else if (advance) begin
            stage_vld[0]  <= transfer;
            stage_data[0] <= stage1_d;
            for (int s = 1; s < STAGES; s++) begin
                stage_vld[s]  <= stage_vld[s-1];
                stage_data[s] <= stage_data[s-1];
            end
        end
    end

    assign out_valid = stage_vld[STAGES-1];
    assign z         = stage_data[STAGES-1];

endmodule

// File: tb/tb_masked_xor_pipe.sv
// Self-checking bench for masked_xor_pipe: several parameterisations share one stimulus bus,
// checked against a share-level reference model and a scoreboard queue.
module tb_masked_xor_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        rnd_valid;
    logic        out_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] rnd;

    logic        rdy0, rdy1, rdy2, rdy3, rdy4;
    logic        ov0, ov1, ov2, ov3, ov4;
    logic [23:0] z0, z1, z3, z4;
    logic [15:0] z2;

    int n_checks = 0;
    int n_pass   = 0;
    int accepted = 0;
    int delivered = 0;
    logic [23:0] sb_q [$];

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] rnd;
        logic [23:0] exp0;
        logic [23:0] exp1;
        logic [15:0] exp2;
    } vec_t;

    vec_t vecs [12];

    masked_xor_pipe #(.WIDTH(8), .SHARES(3), .STAGES(1), .REFRESH(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
        .rnd(rnd), .rnd_valid(rnd_valid), .out_valid(ov0), .out_ready(out_ready), .z(z0));

    masked_xor_pipe #(.WIDTH(8), .SHARES(3), .STAGES(1), .REFRESH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
        .rnd(rnd), .rnd_valid(rnd_valid), .out_valid(ov1), .out_ready(out_ready), .z(z1));

    masked_xor_pipe #(.WIDTH(8), .SHARES(2), .STAGES(1), .REFRESH(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .a(a[15:0]), .b(b[15:0]),
        .rnd(rnd[15:0]), .rnd_valid(rnd_valid), .out_valid(ov2), .out_ready(out_ready), .z(z2));

    masked_xor_pipe #(.WIDTH(8), .SHARES(3), .STAGES(3), .REFRESH(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .a(a), .b(b),
        .rnd(rnd), .rnd_valid(rnd_valid), .out_valid(ov3), .out_ready(out_ready), .z(z3));

    masked_xor_pipe #(.WIDTH(8), .SHARES(3), .STAGES(2), .REFRESH(0)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b),
        .rnd(rnd), .rnd_valid(rnd_valid), .out_valid(ov4), .out_ready(out_ready), .z(z4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each output share is a_i ^ b_i plus the refresh words that the ring rule assigns it.
    function automatic logic [23:0] ref_z(input logic [23:0] av, input logic [23:0] bv,
                                          input logic [23:0] rv, input int shares, input bit refresh);
        logic [23:0] res;
        logic [7:0]  w;
        res = '0;
        for (int i = 0; i < shares; i++) begin
            w = av[i*8 +: 8] ^ bv[i*8 +: 8];
            if (refresh) begin
                if (shares == 2) w = w ^ rv[7:0];
                else             w = w ^ rv[i*8 +: 8] ^ rv[((i + shares - 1) % shares)*8 +: 8];
            end
            res[i*8 +: 8] = w;
        end
        return res;
    endfunction

    function automatic logic [7:0] unshare(input logic [23:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [23:0] av, input logic [23:0] bv, input logic [23:0] rv,
                                 input bit iv, input bit rvld, input bit ordy);
        @(negedge clk);
        a         = av;
        b         = bv;
        rnd       = rv;
        in_valid  = iv;
        rnd_valid = rvld;
        out_ready = ordy;
    endtask

    // One cycle on the STAGES=3 refresh instance with scoreboard bookkeeping.
    task automatic step3(input bit iv, input bit rvld, input bit ordy);
        logic [23:0] av;
        logic [23:0] bv;
        logic [23:0] rv;
        av = 24'($urandom);
        bv = 24'($urandom);
        rv = 24'($urandom);
        applyStimulus(av, bv, rv, iv, rvld, ordy);
        #1;
        checkOutput("u3_in_ready", 64'(rdy3), 64'((!ov3 || ordy) && rvld));
        if (ov3) begin
            if (sb_q.size() == 0) begin
                checkOutput("u3_valid_with_empty_scoreboard", 64'(ov3), 64'(0));
            end else begin
                checkOutput("u3_z", 64'(z3), 64'(sb_q[0]));
                if (ordy) begin
                    void'(sb_q.pop_front());
                    delivered++;
                end
            end
        end
        if (iv && rdy3) begin
            sb_q.push_back(ref_z(av, bv, rv, 3, 1'b1));
            accepted++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_ov;
        logic [23:0] op_b;
        logic [23:0] op_c;

        vecs[0] = '{24'h563412, 24'hAAF00F, 24'h000000, 24'hFCC41D, 24'hFCC41D, 16'hC41D};
        vecs[1] = '{24'h000001, 24'h000200, 24'h442211, 24'h000201, 24'h663154, 16'h1310};
        vecs[2] = '{24'h005AA5, 24'h000000, 24'h00FF3C, 24'h005AA5, 24'hFF9999, 16'h6699};
        vecs[3] = '{24'h005AA5, 24'h000000, 24'h00003C, 24'h005AA5, 24'h006699, 16'h6699};
        for (int i = 4; i < 12; i++) begin
            vecs[i].a    = 24'($urandom);
            vecs[i].b    = 24'($urandom);
            vecs[i].rnd  = 24'($urandom);
            vecs[i].exp0 = ref_z(vecs[i].a, vecs[i].b, vecs[i].rnd, 3, 1'b0);
            vecs[i].exp1 = ref_z(vecs[i].a, vecs[i].b, vecs[i].rnd, 3, 1'b1);
            vecs[i].exp2 = ref_z(vecs[i].a, vecs[i].b, vecs[i].rnd, 2, 1'b1)[15:0];
        end

        rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b1; out_ready = 1'b0;
        a = '0; b = '0; rnd = '0;
        #2;
        checkOutput("reset_out_valid", 64'(ov0), 64'(0));
        checkOutput("reset_z", 64'(z0), 64'(0));
        checkOutput("reset_in_ready_plain", 64'(rdy0), 64'(1));
        checkOutput("reset_in_ready_refresh", 64'(rdy3), 64'(1));
        checkOutput("reset_z_deep", 64'(z3), 64'(0));
        checkOutput("reset_out_valid_deep", 64'(ov3), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        first_ov = -1;
        for (int k = 1; k <= 20 && (accepted < 5 || sb_q.size() > 0); k++) begin
            step3(accepted < 5, 1'b1, !(k >= 4 && k <= 7));
            if (ov3 && first_ov < 0) first_ov = k;
        end
        checkOutput("stall_first_latency", 64'(first_ov), 64'(4));
        checkOutput("stall_delivered", 64'(delivered), 64'(5));
        checkOutput("stall_scoreboard_empty", 64'(sb_q.size()), 64'(0));

        for (int k = 0; k < 300; k++) begin
            step3($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            step3(1'b0, 1'b1, 1'b1);
        end
        checkOutput("random_drain_empty", 64'(sb_q.size()), 64'(0));
        checkOutput("random_delivered_all", 64'(delivered), 64'(accepted));

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].rnd, 1'b1, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_plain_valid", i), 64'(ov0), 64'(1));
            checkOutput($sformatf("vec%0d_plain_z", i), 64'(z0), 64'(vecs[i].exp0));
            checkOutput($sformatf("vec%0d_refresh_z", i), 64'(z1), 64'(vecs[i].exp1));
            checkOutput($sformatf("vec%0d_pair_z", i), 64'(z2), 64'(vecs[i].exp2));
            checkOutput($sformatf("vec%0d_unshared", i), 64'(unshare(z1)),
                        64'(unshare(vecs[i].a) ^ unshare(vecs[i].b)));
        end

        applyStimulus(24'h0, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("bubble_out_valid", 64'(ov0), 64'(0));

        applyStimulus(vecs[1].a, vecs[1].b, vecs[1].rnd, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("no_rnd_in_ready", 64'(rdy1), 64'(0));
        checkOutput("no_rnd_plain_in_ready", 64'(rdy0), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("no_rnd_out_valid", 64'(ov1), 64'(0));
        applyStimulus(vecs[1].a, vecs[1].b, vecs[1].rnd, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("rnd_back_in_ready", 64'(rdy1), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("rnd_back_out_valid", 64'(ov1), 64'(1));
        checkOutput("rnd_back_z", 64'(z1), 64'(24'h663154));

        repeat (3) applyStimulus(24'h0, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
        op_b = 24'($urandom);
        applyStimulus(24'h563412, 24'hAAF00F, 24'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(op_b, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("inflight_out_valid", 64'(ov4), 64'(1));
        checkOutput("inflight_z", 64'(z4), 64'(24'hFCC41D));
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(ov4), 64'(0));
        checkOutput("midreset_z", 64'(z4), 64'(0));
        checkOutput("midreset_in_ready", 64'(rdy4), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(24'h0, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("postreset_idle%0d", k), 64'(ov4), 64'(0));
        end
        op_c = 24'($urandom);
        applyStimulus(op_c, 24'h0F0F0F, 24'h0, 1'b1, 1'b1, 1'b1);
        applyStimulus(24'h0, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("postreset_first_valid", 64'(ov4), 64'(1));
        checkOutput("postreset_first_z", 64'(z4), 64'(ref_z(op_c, 24'h0F0F0F, 24'h0, 3, 1'b0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/masked_xor_pipe.md
Name: masked_xor_pipe

Overview:
- Share-wise XOR of two Boolean-masked operands (d+1 sharing), with optional fresh-randomness ring refresh and a configurable register pipeline under valid/ready flow control.
- Parametrised successor of the plain combinational share XOR used in the masked AES datapath, i.e. AddRoundKey, MixColumns and key-schedule XOR trees.
- The registered stages provide glitch isolation between masked layers.
- The masked value is preserved: the XOR of output shares equals (XOR of a shares) ^ (XOR of b shares).

Parameters:
- WIDTH, 8, bits per share.
- SHARES, 3, number of shares (d+1); legal 2..4.
- STAGES, 1, pipeline register stages; legal 1..4.
- REFRESH, 1, 1 = apply ring refresh in stage 1; 0 = plain share-wise XOR, and rnd/rnd_valid are ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a, b present.
- in_ready  out  1  stage 1 can accept this cycle.
- a  in  SHARES*WIDTH  operand shares; share i = a[i*WIDTH +: WIDTH].
- b  in  SHARES*WIDTH  operand shares, same packing as a.
- rnd  in  SHARES*WIDTH  fresh randomness, words r_0..r_{SHARES-1}.
- rnd_valid  in  1  rnd is fresh this cycle.
- out_valid  out  1  z valid.
- out_ready  in  1  downstream accepts z.
- z  out  SHARES*WIDTH  result shares.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits = 0 and all stage data registers = 0.
  - Resulting outputs: out_valid=0, z=0, in_ready=1.
- Stage-1 data:
  - REFRESH=0: z_i = a_i ^ b_i.
  - REFRESH=1, SHARES>=3: z_i = a_i ^ b_i ^ r_i ^ r_{(i-1) mod SHARES}.
  - REFRESH=1, SHARES=2: z_0 = a_0^b_0^r_0 and z_1 = a_1^b_1^r_0; r_1 is unused.
  - All randomness cancels in the unshared value.
- Pipeline advance:
  - advance = !out_valid || out_ready.
  - All stages shift together when advance=1 and hold when advance=0. No bubble collapsing.
  - Latency = STAGES cycles from accepted input to out_valid, with no stall.
  - Throughput is 1 per cycle.
- Input acceptance:
  - REFRESH=0: in_ready = advance.
  - REFRESH=1: in_ready = advance && rnd_valid.
  - Transfer occurs when in_valid && in_ready.
  - When advance=1 and no transfer occurs, a bubble (valid=0) enters stage 1. Stage-1 data is still loaded; downstream must ignore it.
- Output stability: while out_valid && !out_ready, z and out_valid hold their values.
- Randomness: each rnd word is consumed in at most one transfer. This is the supplier's responsibility; the block does not check it. No combinational path from rnd to z.
- Combinational paths:
  - in_ready depends combinationally on out_ready, out_valid and rnd_valid.
  - z and out_valid are register outputs only.
- Reset mid-operation: all in-flight data is discarded. The first post-reset output is the first transfer after rst_n deasserts.
- Simultaneous events: with out_valid=1, out_ready=1 and in_valid=1, the output is consumed and the input accepted in the same cycle.

Test Plan:
- REFRESH=0, SHARES=3, WIDTH=8, STAGES=1.
  - Stimulus: a={0x12,0x34,0x56}, b={0x0F,0xF0,0xAA}, out_ready=1.
  - Required: one cycle later z={0x1D,0xC4,0xFC}, out_valid=1 for 1 cycle.
- REFRESH=1, SHARES=3.
  - Stimulus: a={0x01,0,0}, b={0,0x02,0}, rnd={0x11,0x22,0x44}.
  - Required: z={0x01^0x11^0x44, 0x02^0x22^0x11, 0x00^0x44^0x22} = {0x54,0x31,0x66}. XOR of shares = 0x03.
- REFRESH=1, rnd_valid=0, in_valid=1.
  - Required: in_ready=0 and no output.
  - Then rnd_valid=1: accepted that cycle, out_valid after STAGES cycles.
- STAGES=3, stream of 5 operands.
  - Hold out_ready=0 for 4 cycles after the first out_valid.
  - Required: z frozen on the first result, in_ready=0 while the pipe is full, all 5 results delivered in order with none lost or duplicated.
- SHARES=2, REFRESH=1.
  - Stimulus: a={0xA5,0x5A}, b=0, rnd={0x3C,0xFF}.
  - Required: z={0x99,0x66}; r_1 has no effect.
- Reset mid-stream, STAGES=2, with 2 operands in flight: assert rst_n=0 for 1 cycle.
  - Required: out_valid=0 and z=0 immediately, with no stale output after release.
